// File: rtl/store_buffer_pkg.sv
// Shared sizing defaults and the queue entry type for the MIPS-Lite posted-write store buffer.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 8;
    localparam int SB_DW    = 8;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store, load and data-memory port bundle of the store buffer; master drives requests and memory read data.
interface store_buffer_if #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int CW = 3
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_stall;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          sb_empty;
    logic [CW-1:0] sb_count;

    modport master (
        output st_valid, st_addr, st_data, ld_req, ld_addr, mem_rdata,
        input  st_ready, ld_data, ld_stall, mem_addr, mem_wdata, mem_we, sb_empty, sb_count
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_req, ld_addr, mem_rdata,
        output st_ready, ld_data, ld_stall, mem_addr, mem_wdata, mem_we, sb_empty, sb_count
    );
endinterface

// File: rtl/store_buffer_match.sv
// Load-address compare across all queued stores; the youngest valid match (closest behind tail) wins.
module store_buffer_match #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid,
    input  logic [AW-1:0]    addr [DEPTH],
    input  logic [DW-1:0]    data [DEPTH],
    input  logic [PW-1:0]    tail,
    input  logic [AW-1:0]    ld_addr,
    output logic             hit,
    output logic [DW-1:0]    hit_data
);

    // Walk oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        hit_data = {DW{1'b0}};
        for (int k = DEPTH; k >= 1; k--) begin
            if (valid[tail - PW'(k)] && (addr[tail - PW'(k)] == ld_addr)) begin
                hit      = 1'b1;
                hit_data = data[tail - PW'(k)];
            end else begin
                hit      = hit;
                hit_data = hit_data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store queue in front of a single-port data memory; loads win the port over draining.
// Build option: define STORE_FWD_EN to forward load hits from the queue instead of stalling them.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input logic           clk,
    input logic           rst,
    store_buffer_if.slave sb
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_r [DEPTH];
    logic [DW-1:0]    data_r [DEPTH];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;
    logic [DEPTH-1:0] valid_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             hit_s;
    logic [DW-1:0]    hit_data_s;

    // Slot i is occupied when its distance from head is below the occupancy count.
    always_comb begin
        valid_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            valid_s[i] = ({1'b0, PW'(i) - head_r} < count_r);
        end
    end

    store_buffer_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) u_match (
        .valid    (valid_s),
        .addr     (addr_r),
        .data     (data_r),
        .tail     (tail_r),
        .ld_addr  (sb.ld_addr),
        .hit      (hit_s),
        .hit_data (hit_data_s)
    );

    // Port arbitration: a load miss owns memory, otherwise the head drains.
    always_comb begin
        full_s  = (count_r == CW'(DEPTH));
        empty_s = (count_r == {CW{1'b0}});
        push_s  = sb.st_valid && !full_s;
        if (sb.ld_req && !hit_s) begin
            pop_s = 1'b0;
        end else begin
            pop_s = !empty_s;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_r[tail_r] <= sb.st_addr;
            data_r[tail_r] <= sb.st_data;
        end
    end

    // Head, tail and occupancy; reset discards every pending store, including one mid-drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                head_r <= head_r + {{(PW-1){1'b0}}, 1'b1};
            end
            count_r <= count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
        end
    end

    // Memory port and load result muxing.
    always_comb begin
        sb.st_ready = !full_s;
        sb.sb_empty = empty_s;
        sb.sb_count = count_r;
        sb.mem_we   = pop_s;
        if (pop_s) begin
            sb.mem_addr  = addr_r[head_r];
            sb.mem_wdata = data_r[head_r];
        end else begin
            sb.mem_addr  = sb.ld_addr;
            sb.mem_wdata = {DW{1'b0}};
        end
`ifdef STORE_FWD_EN
        sb.ld_stall = 1'b0;
        if (hit_s) begin
            sb.ld_data = hit_data_s;
        end else begin
            sb.ld_data = sb.mem_rdata;
        end
`else
        // Without forwarding the hit still blocks the load until the older stores have drained.
        sb.ld_stall = sb.ld_req && hit_s;
        if (hit_s) begin
            sb.ld_data = {DW{1'b0}};
        end else begin
            sb.ld_data = sb.mem_rdata;
        end
`endif
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-and-memory reference model plus directed and random scenarios.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = SB_DEPTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    store_buffer_if #(.AW(SB_AW), .DW(SB_DW), .CW($clog2(SB_DEPTH) + 1)) sbif ();

    store_buffer #(.DEPTH(SB_DEPTH), .AW(SB_AW), .DW(SB_DW)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif.slave)
    );

    logic [7:0] phys_mem [256];
    logic [7:0] ref_mem  [256];

    assign sbif.mem_rdata = phys_mem[sbif.mem_addr];

    always @(posedge clk) begin
        if (sbif.mem_we) phys_mem[sbif.mem_addr] <= sbif.mem_wdata;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: pending stores in program order and the memory image they should produce.
    sb_entry_t  q[$];
    int         exp_count;
    logic       exp_hit, exp_we, exp_stall;
    logic [7:0] exp_hit_data, exp_addr, exp_wdata, exp_ld_data;

    task automatic predict();
        exp_count    = q.size();
        exp_hit      = 1'b0;
        exp_hit_data = 8'h00;
        if (sbif.ld_req) begin
            foreach (q[i]) begin
                if (q[i].addr == sbif.ld_addr) begin
                    exp_hit      = 1'b1;
                    exp_hit_data = q[i].data;
                end
            end
        end
        exp_we    = !(sbif.ld_req && !exp_hit) && (q.size() > 0);
        exp_addr  = sbif.ld_addr;
        exp_wdata = 8'h00;
        if (exp_we) begin
            exp_addr  = q[0].addr;
            exp_wdata = q[0].data;
        end
`ifdef STORE_FWD_EN
        exp_stall   = 1'b0;
        exp_ld_data = exp_hit ? exp_hit_data : ref_mem[sbif.ld_addr];
`else
        exp_stall   = exp_hit;
        exp_ld_data = ref_mem[sbif.ld_addr];
`endif
    endtask

    task automatic drive(input logic sv, input logic [7:0] sa, input logic [7:0] sd,
                         input logic lr, input logic [7:0] la);
        sbif.st_valid = sv;
        sbif.st_addr  = sa;
        sbif.st_data  = sd;
        sbif.ld_req   = lr;
        sbif.ld_addr  = la;
        #1;
        predict();
    endtask

    task automatic tick();
        logic      push_ok;
        logic      pop_ok;
        sb_entry_t e;
        push_ok = sbif.st_valid && (q.size() < DEPTH);
        pop_ok  = exp_we;
        e.addr  = sbif.st_addr;
        e.data  = sbif.st_data;
        @(posedge clk);
        if (pop_ok) begin
            ref_mem[q[0].addr] = q[0].data;
            void'(q.pop_front());
        end
        if (push_ok) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h05);
        total++;
        if (sbif.sb_count !== 3'd0 || sbif.sb_empty !== 1'b1 || sbif.st_ready !== 1'b1 ||
            sbif.mem_we !== 1'b0 || sbif.ld_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got count=%0d empty=%b ready=%b we=%b stall=%b exp 0 1 1 0 0",
                     sbif.sb_count, sbif.sb_empty, sbif.st_ready, sbif.mem_we, sbif.ld_stall);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        int diffs;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h50 + 8'(i), 8'($urandom), 1'b1, 8'h05);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        total++;
        if (sbif.sb_count !== 3'd3 || sbif.mem_we !== 1'b1 || sbif.mem_addr !== 8'h50) begin
            bad++;
            $display("FAIL mid_drain_setup got count=%0d we=%b addr=%0h exp 3 1 50",
                     sbif.sb_count, sbif.mem_we, sbif.mem_addr);
        end
        tick();
        rst = 1'b1;
        q.delete();
        #1;
        total++;
        if (sbif.sb_count !== 3'd0 || sbif.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL mid_drain_reset got count=%0d we=%b exp 0 0", sbif.sb_count, sbif.mem_we);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
            total++;
            if (sbif.mem_we !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_we cycle=%0d got=%b exp=0", i, sbif.mem_we);
            end
            tick();
        end
        diffs = 0;
        for (int a = 0; a < 256; a++) if (phys_mem[a] !== ref_mem[a]) diffs++;
        total++;
        if (diffs != 0) begin
            bad++;
            $display("FAIL post_reset_mem got %0d differing bytes exp 0", diffs);
        end
    endtask

    task automatic test_single_store();
        drive(1'b1, 8'h10, 8'hAA, 1'b0, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        total++;
        if (sbif.mem_we !== 1'b1 || sbif.mem_addr !== 8'h10 || sbif.mem_wdata !== 8'hAA) begin
            bad++;
            $display("FAIL single_store_write got we=%b addr=%0h wdata=%0h exp 1 10 aa",
                     sbif.mem_we, sbif.mem_addr, sbif.mem_wdata);
        end
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        total++;
        if (sbif.sb_empty !== 1'b1 || phys_mem[8'h10] !== 8'hAA) begin
            bad++;
            $display("FAIL single_store_done got empty=%b mem=%0h exp 1 aa", sbif.sb_empty, phys_mem[8'h10]);
        end
    endtask

    task automatic test_fill();
        logic [7:0] d [4];
        for (int i = 0; i < 4; i++) begin
            d[i] = 8'($urandom);
            drive(1'b1, 8'h30 + 8'(i), d[i], 1'b1, 8'h05);
            total++;
            if (sbif.st_ready !== 1'b1 || sbif.mem_we !== 1'b0) begin
                bad++;
                $display("FAIL fill_ready slot=%0d got ready=%b we=%b exp 1 0", i, sbif.st_ready, sbif.mem_we);
            end
            tick();
        end
        drive(1'b1, 8'h3F, 8'h77, 1'b1, 8'h05);
        total++;
        if (sbif.st_ready !== 1'b0 || sbif.sb_count !== 3'd4) begin
            bad++;
            $display("FAIL fill_full got ready=%b count=%0d exp 0 4", sbif.st_ready, sbif.sb_count);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
            total++;
            if (sbif.mem_we !== 1'b1 || sbif.mem_addr !== 8'h30 + 8'(i) || sbif.mem_wdata !== d[i]) begin
                bad++;
                $display("FAIL fill_drain_order slot=%0d got we=%b addr=%0h wdata=%0h exp 1 %0h %0h",
                         i, sbif.mem_we, sbif.mem_addr, sbif.mem_wdata, 8'h30 + 8'(i), d[i]);
            end
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        total++;
        if (sbif.sb_empty !== 1'b1 || phys_mem[8'h3F] !== ref_mem[8'h3F]) begin
            bad++;
            $display("FAIL fill_dropped got empty=%b mem3f=%0h exp 1 %0h", sbif.sb_empty, phys_mem[8'h3F], ref_mem[8'h3F]);
        end
    endtask

    task automatic test_forward();
        drive(1'b1, 8'h20, 8'h11, 1'b1, 8'h05);
        tick();
        drive(1'b1, 8'h20, 8'h22, 1'b1, 8'h05);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h20);
`ifdef STORE_FWD_EN
        for (int c = 0; c < 2; c++) begin
            total++;
            if (sbif.ld_stall !== 1'b0 || sbif.ld_data !== 8'h22 || sbif.mem_we !== 1'b1 ||
                sbif.mem_wdata !== (c == 0 ? 8'h11 : 8'h22)) begin
                bad++;
                $display("FAIL fwd_hit cycle=%0d got stall=%b data=%0h we=%b wdata=%0h exp 0 22 1 %0h",
                         c, sbif.ld_stall, sbif.ld_data, sbif.mem_we, sbif.mem_wdata, c == 0 ? 8'h11 : 8'h22);
            end
            tick();
            drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h20);
        end
`else
        for (int c = 0; c < 2; c++) begin
            total++;
            if (sbif.ld_stall !== 1'b1 || sbif.mem_we !== 1'b1 || sbif.mem_wdata !== (c == 0 ? 8'h11 : 8'h22)) begin
                bad++;
                $display("FAIL stall_hit cycle=%0d got stall=%b we=%b wdata=%0h exp 1 1 %0h",
                         c, sbif.ld_stall, sbif.mem_we, sbif.mem_wdata, c == 0 ? 8'h11 : 8'h22);
            end
            tick();
            drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h20);
        end
`endif
        total++;
        if (sbif.ld_stall !== 1'b0 || sbif.ld_data !== 8'h22 || sbif.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL hit_from_mem got stall=%b data=%0h we=%b exp 0 22 0", sbif.ld_stall, sbif.ld_data, sbif.mem_we);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'h60 + 8'(i), 8'($urandom), 1'b1, 8'h05);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 8'h62 + 8'(k), 8'($urandom), 1'b0, 8'h00);
            total++;
            if (sbif.sb_count !== 3'd2 || sbif.mem_we !== 1'b1 || sbif.mem_addr !== 8'h60 + 8'(n) ||
                sbif.mem_wdata !== exp_wdata) begin
                bad++;
                $display("FAIL push_pop_wrap step=%0d got count=%0d we=%b addr=%0h wdata=%0h exp 2 1 %0h %0h",
                         k, sbif.sb_count, sbif.mem_we, sbif.mem_addr, sbif.mem_wdata, 8'h60 + 8'(n), exp_wdata);
            end
            n++;
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
            total++;
            if (sbif.mem_we !== 1'b1 || sbif.mem_addr !== 8'h60 + 8'(n)) begin
                bad++;
                $display("FAIL wrap_tail step=%0d got we=%b addr=%0h exp 1 %0h", k, sbif.mem_we, sbif.mem_addr, 8'h60 + 8'(n));
            end
            n++;
            tick();
        end
    endtask

    task automatic test_load_miss();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'h70 + 8'(i), 8'($urandom), 1'b1, 8'h05);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h05);
        total++;
        if (sbif.mem_we !== 1'b0 || sbif.mem_addr !== 8'h05 || sbif.ld_stall !== 1'b0 ||
            sbif.ld_data !== ref_mem[8'h05] || sbif.sb_count !== 3'd2) begin
            bad++;
            $display("FAIL load_miss got we=%b addr=%0h stall=%b data=%0h count=%0d exp 0 05 0 %0h 2",
                     sbif.mem_we, sbif.mem_addr, sbif.ld_stall, sbif.ld_data, sbif.sb_count, ref_mem[8'h05]);
        end
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        total++;
        if (sbif.sb_count !== 3'd2) begin
            bad++;
            $display("FAIL load_miss_hold got count=%0d exp 2", sbif.sb_count);
        end
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        tick();
    endtask

    task automatic test_random();
        int diffs;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 3)), 8'($urandom),
                  ($urandom_range(0, 2) == 0), 8'h40 + 8'($urandom_range(0, 4)));
            total++;
            if (int'(sbif.sb_count) !== exp_count || sbif.st_ready !== (exp_count < DEPTH) ||
                sbif.sb_empty !== (exp_count == 0)) begin
                bad++;
                $display("FAIL rand_occupancy cycle=%0d got count=%0d ready=%b empty=%b exp count=%0d",
                         c, sbif.sb_count, sbif.st_ready, sbif.sb_empty, exp_count);
            end
            total++;
            if (sbif.mem_we !== exp_we || sbif.mem_addr !== exp_addr || (exp_we && sbif.mem_wdata !== exp_wdata)) begin
                bad++;
                $display("FAIL rand_port cycle=%0d got we=%b addr=%0h wdata=%0h exp %b %0h %0h",
                         c, sbif.mem_we, sbif.mem_addr, sbif.mem_wdata, exp_we, exp_addr, exp_wdata);
            end
            total++;
            if (sbif.ld_stall !== exp_stall || (sbif.ld_req && !exp_stall && sbif.ld_data !== exp_ld_data)) begin
                bad++;
                $display("FAIL rand_load cycle=%0d got stall=%b data=%0h exp %b %0h",
                         c, sbif.ld_stall, sbif.ld_data, exp_stall, exp_ld_data);
            end
            tick();
        end
        for (int c = 0; c < DEPTH; c++) begin
            drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
            tick();
        end
        diffs = 0;
        for (int a = 0; a < 256; a++) if (phys_mem[a] !== ref_mem[a]) diffs++;
        total++;
        if (sbif.sb_empty !== 1'b1 || diffs != 0) begin
            bad++;
            $display("FAIL rand_final got empty=%b diff_bytes=%0d exp 1 0", sbif.sb_empty, diffs);
        end
    endtask

    initial begin
        rst           = 1'b1;
        sbif.st_valid = 1'b0;
        sbif.st_addr  = 8'h00;
        sbif.st_data  = 8'h00;
        sbif.ld_req   = 1'b0;
        sbif.ld_addr  = 8'h00;
        for (int a = 0; a < 256; a++) begin
            phys_mem[a] = 8'($urandom);
            ref_mem[a]  = phys_mem[a];
        end
        test_reset();
        test_reset_mid_drain();
        test_single_store();
        test_fill();
        test_forward();
        test_back_to_back();
        test_load_miss();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
